gate_sweep_checker: RTL and testbench
=====================================

// Module: gate_sweep_checker
// PURPOSE
//   Synthesizable self-checking harness for one 2-input combinational gate (AND/OR/NAND...).
//   Drives the gate inputs a,b through all four combinations {a,b}=00,01,10,11 and samples the gate output y.
//   Compares each sample against a parameterized truth table and reports a pass/fail summary.
//   Sits between a start source (button/bench) and any 2-input gate DUT.
// PARAMETERS
//   EXPECT         4'b1110  expected y per vector; EXPECT[{a,b}] (1110 = OR, 1000 = AND, 0111 = NAND)
//   SETTLE_CYCLES  2        extra hold cycles per vector before sampling; legal 0..255
//   CNT_W          4        width of err_count; legal 1..8
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin sweep; sampled only in IDLE
//   y_in       in   1      output of gate under check
//   a_out      out  1      gate input a (= idx[1])
//   b_out      out  1      gate input b (= idx[0])
//   busy       out  1      high while sweeping (state DRIVE)
//   done       out  1      single-cycle pulse at sweep end
//   pass       out  1      1 = last sweep had zero mismatches; held until next accepted start
//   err_count  out  CNT_W  mismatch count, saturating at 2^CNT_W-1
//   fail_vec   out  4      fail_vec[i]=1 -> vector i mismatched (never saturates)
// BEHAVIOUR
//   Reset (rst=1 at an edge, any state): state=IDLE, idx=0, cnt=0, a_out=b_out=0,
//     busy=done=pass=0, err_count=0, fail_vec=0. rst overrides start.
//   FSM states: IDLE, DRIVE, DONE.
//   IDLE: start=1 at edge E0 -> DRIVE; idx=0, cnt=0, err_count=0, fail_vec=0, pass=0.
//     Otherwise stay; pass/err_count/fail_vec retain the previous sweep's results.
//   DRIVE: busy=1; {a_out,b_out}=idx; cnt increments every cycle.
//     At the edge where cnt==SETTLE_CYCLES: sample y_in.
//     If y_in != EXPECT[idx]: set fail_vec[idx]; increment err_count unless already at max.
//     Then cnt=0. If idx==3 -> DONE, else idx=idx+1.
//     Each vector is held for exactly SETTLE_CYCLES+1 cycles; the sample is taken on the vector's final edge.
//   DONE: lasts one cycle; busy=0, done=1; pass=(err_count==0) from this cycle on; -> IDLE.
//     a_out/b_out return to 0 in DONE and IDLE.
//   Latency: done is high in the cycle after edge E0+4*(SETTLE_CYCLES+1)
//     (SETTLE_CYCLES=2 -> 12 cycles after busy rises).
//   start while in DRIVE or DONE is ignored: no restart and no queuing.
//     start held high continuously -> a new sweep begins on the first IDLE edge.
//   SETTLE_CYCLES=0: one cycle per vector; sweep lasts 4 cycles.
//   idx never wraps within a sweep; err_count maximum is min(4, 2^CNT_W-1).
//   y_in X/Z is a bench error; RTL needs no special handling.
// TESTING
//   1 rst for 2 cycles, start=0 -> a_out=b_out=busy=done=pass=0, err_count=0, fail_vec=0.
//   2 Defaults; y_in=a_out|b_out; start pulse -> vectors 00,01,10,11 each held 3 cycles;
//     done pulse 12 cycles after busy; pass=1, err_count=0, fail_vec=0000.
//   3 y_in=a_out&b_out with EXPECT=1110 -> err_count=2, fail_vec=0110, pass=0.
//   4 y_in stuck 0 with CNT_W=1 -> fail_vec=1110, err_count saturates at 1, pass=0.
//   5 Extra start pulses during busy and in the DONE cycle -> single sweep; done pulses exactly once.
//     A following start in IDLE clears the results and reruns the sweep.
//   6 rst asserted while idx=2 -> next cycle all reset values.
//     A later start runs a full 4-vector sweep; pass=1 with y_in=a_out|b_out.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Sweeps a 2-input gate through {a,b}=00..11, compares each settled output with a
// truth table and reports pass, a saturating mismatch count and a per-vector fail mask.
module gate_sweep_checker #(
    parameter logic [3:0]  EXPECT        = 4'b1110,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            err_q   <= '0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrive;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    err_d   = '0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            StDrive: begin
                if (cnt_q == SettleLast) begin
                    cnt_d = 8'd0;
                    if (y_in != EXPECT[idx_q]) begin
                        fail_d[idx_q] = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
                    end
                    // pass is registered on the last sample so it is already valid in DONE
                    if (idx_q == 2'd3) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = 2'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q == StDrive);
    assign done      = (state_q == StDone);
    assign a_out     = busy & idx_q[1];
    assign b_out     = busy & idx_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (default, and SETTLE_CYCLES=0 / CNT_W=1)
// driven with random gate truth tables and checked against a truth-table model.
module tb_gate_sweep_checker;

    localparam logic [3:0] Exp = 4'b1110;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a [2];
    logic [3:0] g_a     [2];
    logic       y_a     [2];
    logic       a_a     [2];
    logic       b_a     [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic       pass_a  [2];
    logic [3:0] err_a   [2];
    logic [3:0] fail_a  [2];
    logic       err1;

    int         checks = 0;
    int         passes = 0;
    logic [1:0] obs[$];
    int         lat;
    int         ndone;
    logic       pass_done;

    always #5 clk = ~clk;

    // Simulated gate under check: its truth table is g_a[d], indexed by {a,b}.
    assign y_a[0]   = g_a[0][{a_a[0], b_a[0]}];
    assign y_a[1]   = g_a[1][{a_a[1], b_a[1]}];
    assign err_a[1] = {3'b000, err1};

    gate_sweep_checker #(.EXPECT(Exp), .SETTLE_CYCLES(2), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .y_in(y_a[0]),
        .a_out(a_a[0]), .b_out(b_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .err_count(err_a[0]), .fail_vec(fail_a[0])
    );

    gate_sweep_checker #(.EXPECT(Exp), .SETTLE_CYCLES(0), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .y_in(y_a[1]),
        .a_out(a_a[1]), .b_out(b_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .err_count(err1), .fail_vec(fail_a[1])
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int maxerr_of(input int d);
        return (d == 0) ? 15 : 1;
    endfunction

    function automatic logic [3:0] m_fail(input logic [3:0] g);
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = (g[i] != Exp[i]);
        return f;
    endfunction

    function automatic int m_err(input int d, input logic [3:0] g);
        int n = 0;
        for (int i = 0; i < 4; i++) if (g[i] != Exp[i]) n++;
        return (n > maxerr_of(d)) ? maxerr_of(d) : n;
    endfunction

    function automatic int m_lat(input int d);
        return 4 * (settle_of(d) + 1) + 1;
    endfunction

    // Expected trace: vector k/(S+1) on busy cycle k, 4*(S+1) cycles in total.
    function automatic bit trace_ok(input int d);
        int hold = settle_of(d) + 1;
        if (obs.size() != 4 * hold) return 1'b0;
        for (int k = 0; k < obs.size(); k++) begin
            if (obs[k] != 2'(k / hold)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Starts one sweep and records the vector trace, done latency/count and pass at done.
    // noisy=1 also pulses start during busy and in the DONE cycle.
    task automatic run_sweep(input int d, input bit noisy);
        obs.delete();
        lat       = -1;
        ndone     = 0;
        pass_done = 1'b0;
        @(negedge clk);
        start_a[d] = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start_a[d] = 1'b0;
            if (busy_a[d]) obs.push_back({a_a[d], b_a[d]});
            if (done_a[d]) begin
                ndone++;
                if (lat < 0) begin
                    lat       = n;
                    pass_done = pass_a[d];
                end
                if (noisy) start_a[d] = 1'b1;
            end else if (noisy && busy_a[d] && ($urandom_range(0, 1) == 1)) begin
                start_a[d] = 1'b1;
            end
            if (lat >= 0 && n >= lat + 4) break;
        end
        start_a[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({a_a[d], b_a[d], busy_a[d], done_a[d], pass_a[d]} !== 5'b0)
                $display("FAIL reset_ctrl dut%0d got a,b,busy,done,pass=%b want 00000", d,
                         {a_a[d], b_a[d], busy_a[d], done_a[d], pass_a[d]});
            else passes++;
            checks++;
            if (err_a[d] !== 4'd0) $display("FAIL reset_err dut%0d got %0d want 0", d, err_a[d]);
            else passes++;
            checks++;
            if (fail_a[d] !== 4'd0) $display("FAIL reset_fail dut%0d got %b want 0000", d, fail_a[d]);
            else passes++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_or_pass();
        g_a[0] = 4'b1110;
        run_sweep(0, 1'b0);
        checks++;
        if (lat !== m_lat(0)) $display("FAIL or_latency got %0d want %0d", lat, m_lat(0));
        else passes++;
        checks++;
        if (!trace_ok(0)) $display("FAIL or_trace got %0d busy cycles, wrong vector order", obs.size());
        else passes++;
        checks++;
        if ({pass_done, pass_a[0]} !== 2'b11) $display("FAIL or_pass got %b want 11", {pass_done, pass_a[0]});
        else passes++;
        checks++;
        if ({err_a[0], fail_a[0]} !== 8'h00) $display("FAIL or_results got err=%0d fail=%b want 0/0000", err_a[0], fail_a[0]);
        else passes++;
    endtask

    task automatic test_and_mismatch();
        g_a[0] = 4'b1000;
        run_sweep(0, 1'b0);
        checks++;
        if (err_a[0] !== 4'd2) $display("FAIL and_err got %0d want 2", err_a[0]);
        else passes++;
        checks++;
        if (fail_a[0] !== 4'b0110) $display("FAIL and_fail got %b want 0110", fail_a[0]);
        else passes++;
        checks++;
        if ({pass_done, pass_a[0]} !== 2'b00) $display("FAIL and_pass got %b want 00", {pass_done, pass_a[0]});
        else passes++;
    endtask

    task automatic test_stuck_saturate();
        g_a[1] = 4'b0000;
        run_sweep(1, 1'b0);
        checks++;
        if (lat !== m_lat(1)) $display("FAIL stuck_latency got %0d want %0d", lat, m_lat(1));
        else passes++;
        checks++;
        if (fail_a[1] !== 4'b1110) $display("FAIL stuck_fail got %b want 1110", fail_a[1]);
        else passes++;
        checks++;
        if ({err_a[1], pass_a[1]} !== 5'b00010) $display("FAIL stuck_err_pass got err=%0d pass=%b want 1/0", err_a[1], pass_a[1]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        g_a[0] = 4'b0111;
        run_sweep(0, 1'b1);
        checks++;
        if (ndone !== 1) $display("FAIL b2b_done_count got %0d want 1", ndone);
        else passes++;
        checks++;
        if (!trace_ok(0)) $display("FAIL b2b_trace got %0d busy cycles want %0d", obs.size(), 12);
        else passes++;
        checks++;
        if (fail_a[0] !== m_fail(4'b0111)) $display("FAIL b2b_fail got %b want %b", fail_a[0], m_fail(4'b0111));
        else passes++;
        g_a[0] = 4'b1110;
        run_sweep(0, 1'b0);
        checks++;
        if ({pass_a[0], err_a[0], fail_a[0]} !== 9'b1_0000_0000)
            $display("FAIL b2b_rerun got pass=%b err=%0d fail=%b want 1/0/0000", pass_a[0], err_a[0], fail_a[0]);
        else passes++;
    endtask

    task automatic test_reset_mid_sweep();
        bit found = 1'b0;
        g_a[0] = 4'b0000;
        @(negedge clk);
        start_a[0] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            start_a[0] = 1'b0;
            if (busy_a[0] && a_a[0] && !b_a[0]) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) $display("FAIL midrst_reach got no idx=2 cycle want one within 30 cycles");
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({a_a[0], b_a[0], busy_a[0], done_a[0], pass_a[0], err_a[0], fail_a[0]} !== 13'd0)
            $display("FAIL midrst_values got a,b,busy,done,pass,err,fail=%b want all 0",
                     {a_a[0], b_a[0], busy_a[0], done_a[0], pass_a[0], err_a[0], fail_a[0]});
        else passes++;
        g_a[0] = 4'b1110;
        run_sweep(0, 1'b0);
        checks++;
        if (!trace_ok(0) || pass_a[0] !== 1'b1)
            $display("FAIL midrst_rerun got busy cycles=%0d pass=%b want 12/1", obs.size(), pass_a[0]);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int d = int'($urandom_range(0, 1));
            logic [3:0] g = 4'($urandom);
            g_a[d] = g;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sweep(d, 1'($urandom_range(0, 1)));
            checks++;
            if (lat !== m_lat(d) || ndone !== 1)
                $display("FAIL rnd%0d_timing dut%0d got lat=%0d done=%0d want %0d/1", i, d, lat, ndone, m_lat(d));
            else passes++;
            checks++;
            if (!trace_ok(d)) $display("FAIL rnd%0d_trace dut%0d got %0d busy cycles", i, d, obs.size());
            else passes++;
            checks++;
            if (fail_a[d] !== m_fail(g)) $display("FAIL rnd%0d_fail g=%b got %b want %b", i, g, fail_a[d], m_fail(g));
            else passes++;
            checks++;
            if (err_a[d] !== 4'(m_err(d, g))) $display("FAIL rnd%0d_err g=%b got %0d want %0d", i, g, err_a[d], m_err(d, g));
            else passes++;
            checks++;
            if ({pass_done, pass_a[d]} !== {2{m_fail(g) == 4'd0}})
                $display("FAIL rnd%0d_pass g=%b got %b want %b", i, g, {pass_done, pass_a[d]}, {2{m_fail(g) == 4'd0}});
            else passes++;
        end
    endtask

    initial begin
        start_a[0] = 1'b0;
        start_a[1] = 1'b0;
        g_a[0]     = 4'b1110;
        g_a[1]     = 4'b1110;
        test_reset();
        test_or_pass();
        test_and_mismatch();
        test_stuck_saturate();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
